// File: rtl/count_control_if.sv
// Button/control bundle between the run/pause/clear controller and its neighbours.
// The master side drives the button levels; the slave side (count_control) drives
// the tick, clear and status outputs.
interface count_control_if;
   logic       btn_run;
   logic       btn_clr;
   logic       enable;
   logic       clear;
   logic       running;
   logic [1:0] state;

   modport master (
      output btn_run,
      output btn_clr,
      input  enable,
      input  clear,
      input  running,
      input  state
   );

   modport slave (
      input  btn_run,
      input  btn_clr,
      output enable,
      output clear,
      output running,
      output state
   );
endinterface

// File: rtl/count_control.sv
// Run/pause/clear controller and enable-tick prescaler feeding the counter chain.
// Button levels become single-cycle rise events. These events drive a four-state FSM
// (IDLE/RUN/PAUSE/CLEAR). RUN emits a one-cycle enable every TICK_DIV clocks.
// CLEAR emits a CLR_CYCLES-long clear pulse.
// Build option: define SYNC_IN_EN to pass both buttons through 2-flop synchronizers
// before edge detection (adds two cycles of event latency).
module count_control #(
   parameter int unsigned TICK_DIV   = 50000,
   parameter int unsigned PRE_W      = 16,
   parameter int unsigned CLR_CYCLES = 2
) (
   input logic            clk,
   input logic            rst_n,
   count_control_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StRun   = 2'b01,
      StPause = 2'b10,
      StClear = 2'b11
   } state_e;

   localparam logic [PRE_W-1:0] TickLast = PRE_W'(TICK_DIV - 1);
   localparam logic [3:0]       ClrLast  = 4'(CLR_CYCLES - 1);

   state_e           state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [3:0]       clr_cnt_q, clr_cnt_d;
   logic             enable_q, enable_d;
   logic             clear_q, clear_d;
   logic             running_q;
   logic             run_hist_q, clr_hist_q;
   logic             run_in, clr_in;
   logic             run_rise, clr_rise;

`ifdef SYNC_IN_EN
   logic [1:0] run_sync_q, clr_sync_q;

   // Two-flop synchronizers for the asynchronous button levels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_sync_q <= 2'b00;
         clr_sync_q <= 2'b00;
      end else begin
         run_sync_q <= {run_sync_q[0], bus.btn_run};
         clr_sync_q <= {clr_sync_q[0], bus.btn_clr};
      end
   end

   assign run_in = run_sync_q[1];
   assign clr_in = clr_sync_q[1];
`else
   assign run_in = bus.btn_run;
   assign clr_in = bus.btn_clr;
`endif

   // History flops reset to 0, so a button already high at reset release is an edge
   assign run_rise = run_in & ~run_hist_q;
   assign clr_rise = clr_in & ~clr_hist_q;

   // Next state, prescaler and registered outputs, all decoded from the current state
   always_comb begin
      state_d   = state_q;
      pre_d     = pre_q;
      clr_cnt_d = clr_cnt_q;
      enable_d  = 1'b0;
      clear_d   = 1'b0;
      case (state_q)
         StIdle: begin
            pre_d = '0;
            if (clr_rise)      state_d = StClear;
            else if (run_rise) state_d = StRun;
         end
         StRun: begin
            // A tick due on the same edge as leaving RUN is still emitted
            if (pre_q == TickLast) begin
               pre_d    = '0;
               enable_d = 1'b1;
            end else begin
               pre_d = pre_q + 1'b1;
            end
            if (clr_rise)      state_d = StClear;
            else if (run_rise) state_d = StPause;
         end
         StPause: begin
            // Prescaler holds so resume keeps the tick phase
            if (clr_rise)      state_d = StClear;
            else if (run_rise) state_d = StRun;
         end
         StClear: begin
            // Button edges are ignored until the clear pulse completes
            pre_d   = '0;
            clear_d = 1'b1;
            if (clr_cnt_q == ClrLast) begin
               clr_cnt_d = '0;
               state_d   = StIdle;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, counters, edge history and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         pre_q      <= '0;
         clr_cnt_q  <= '0;
         enable_q   <= 1'b0;
         clear_q    <= 1'b0;
         running_q  <= 1'b0;
         run_hist_q <= 1'b0;
         clr_hist_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         clr_cnt_q  <= clr_cnt_d;
         enable_q   <= enable_d;
         clear_q    <= clear_d;
         running_q  <= (state_d == StRun);
         run_hist_q <= run_in;
         clr_hist_q <= clr_in;
      end
   end

   assign bus.enable  = enable_q;
   assign bus.clear   = clear_q;
   assign bus.running = running_q;
   assign bus.state   = state_q;

endmodule

// File: tb/tb_count_control.sv
// Bench for count_control with TICK_DIV=4, CLR_CYCLES=2, SYNC_IN_EN undefined.
// A mode/run-time model predicts every output each cycle; directed steps add
// hand-computed literal expectations at the interesting edges.
module tb_count_control;
   localparam int TickDiv = 4;
   localparam int ClrCyc  = 2;
   localparam int MIdle   = 0;
   localparam int MRun    = 1;
   localparam int MPause  = 2;
   localparam int MClear  = 3;

   logic clk = 1'b0;
   logic rst_n;
   bit   chk_on = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   count_control_if bus ();

   count_control #(
      .TICK_DIV   (TickDiv),
      .PRE_W      (16),
      .CLR_CYCLES (ClrCyc)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: mode plus total cycles spent running since the last clear/idle.
   // A tick follows every RUN cycle that brings the running total to a multiple of TickDiv.
   int   m_mode;
   int   m_run_cycles;
   int   m_clr_left;
   logic m_prev_run, m_prev_clr, m_rr, m_cr;
   logic exp_enable, exp_clear;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode       = MIdle;
         m_run_cycles = 0;
         m_clr_left   = 0;
         m_prev_run   = 1'b0;
         m_prev_clr   = 1'b0;
         exp_enable   = 1'b0;
         exp_clear    = 1'b0;
      end else begin
         m_rr       = bus.btn_run && !m_prev_run;
         m_cr       = bus.btn_clr && !m_prev_clr;
         m_prev_run = bus.btn_run;
         m_prev_clr = bus.btn_clr;
         exp_enable = 1'b0;
         exp_clear  = 1'b0;
         if (m_mode == MRun) begin
            m_run_cycles++;
            exp_enable = (m_run_cycles % TickDiv) == 0;
         end
         if (m_mode == MClear) begin
            exp_clear = 1'b1;
            m_clr_left--;
            if (m_clr_left == 0) m_mode = MIdle;
         end else if (m_cr) begin
            m_mode       = MClear;
            m_clr_left   = ClrCyc;
            m_run_cycles = 0;
         end else if (m_rr) begin
            m_mode = (m_mode == MRun) ? MPause : MRun;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_on) begin
         check("model_enable", {31'd0, bus.enable}, {31'd0, exp_enable});
         check("model_clear", {31'd0, bus.clear}, {31'd0, exp_clear});
         check("model_state", {30'd0, bus.state}, m_mode);
         check("model_running", {31'd0, bus.running}, (m_mode == MRun) ? 1 : 0);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bus.btn_run = 1'b0;
      bus.btn_clr = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      chk_on = 1'b1;
      step(2);
      rst_n = 1'b1;
      // Cycle 0
      check("reset_state", {30'd0, bus.state}, 0);
      check("reset_enable", {31'd0, bus.enable}, 0);
      check("reset_clear", {31'd0, bus.clear}, 0);
      check("reset_running", {31'd0, bus.running}, 0);

      // Start: RUN at edge 1, ticks after edges 5, 9, 13
      bus.btn_run = 1'b1;
      for (int e = 1; e <= 13; e++) begin
         step(1);
         if (e == 1) begin
            check("start_state", {30'd0, bus.state}, 1);
            check("start_running", {31'd0, bus.running}, 1);
            bus.btn_run = 1'b0;
         end
         check("tick_phase", {31'd0, bus.enable}, (e >= 5 && (e - 1) % 4 == 0) ? 1 : 0);
      end

      // Pause at edge 16 with prescaler at 3, hold 20 cycles
      step(2);
      bus.btn_run = 1'b1;
      step(1);
      check("pause_state", {30'd0, bus.state}, 2);
      bus.btn_run = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("pause_no_tick", {31'd0, bus.enable}, 0);
      end
      // Resume at edge 37: tick due one cycle later, after edge 38
      bus.btn_run = 1'b1;
      step(1);
      check("resume_state", {30'd0, bus.state}, 1);
      check("resume_enable0", {31'd0, bus.enable}, 0);
      bus.btn_run = 1'b0;
      step(1);
      check("resume_phase_tick", {31'd0, bus.enable}, 1);

      // Clear requested on the edge a tick is due (edge 42)
      step(3);
      bus.btn_clr = 1'b1;
      step(1);
      check("clr_entry_state", {30'd0, bus.state}, 3);
      check("clr_entry_tick", {31'd0, bus.enable}, 1);
      check("clr_entry_clear", {31'd0, bus.clear}, 0);
      bus.btn_clr = 1'b0;
      step(1);
      check("clr_pulse1", {31'd0, bus.clear}, 1);
      check("clr_pulse1_en", {31'd0, bus.enable}, 0);
      step(1);
      check("clr_pulse2", {31'd0, bus.clear}, 1);
      check("clr_exit_state", {30'd0, bus.state}, 0);
      step(1);
      check("clr_done", {31'd0, bus.clear}, 0);

      // Into PAUSE, then simultaneous run+clear edges: clear wins
      bus.btn_run = 1'b1;
      step(1);
      bus.btn_run = 1'b0;
      step(1);
      bus.btn_run = 1'b1;
      step(1);
      check("pause2_state", {30'd0, bus.state}, 2);
      bus.btn_run = 1'b0;
      step(1);
      bus.btn_run = 1'b1;
      bus.btn_clr = 1'b1;
      step(1);
      check("both_clear_wins", {30'd0, bus.state}, 3);
      bus.btn_run = 1'b0;
      bus.btn_clr = 1'b0;
      step(1);
      // Run edge sampled during CLEAR is ignored
      bus.btn_run = 1'b1;
      step(2);
      check("edge_in_clear_ignored", {30'd0, bus.state}, 0);

      // Level held for 50 cycles gives one transition
      bus.btn_run = 1'b0;
      step(1);
      bus.btn_run = 1'b1;
      step(50);
      check("held_one_transition", {30'd0, bus.state}, 1);
      bus.btn_run = 1'b0;

      // Reset during the clear pulse
      bus.btn_clr = 1'b1;
      step(1);
      check("clr2_state", {30'd0, bus.state}, 3);
      step(1);
      check("clr2_pulse", {31'd0, bus.clear}, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_clear", {31'd0, bus.clear}, 0);
      check("async_rst_state", {30'd0, bus.state}, 0);
      check("async_rst_enable", {31'd0, bus.enable}, 0);
      step(2);
      // Button still high at release counts as a fresh edge
      rst_n = 1'b1;
      step(1);
      check("post_rst_edge", {30'd0, bus.state}, 3);
      bus.btn_clr = 1'b0;
      step(6);
      check("final_idle", {30'd0, bus.state}, 0);

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
